// File: rtl/comp_1b_pkg.sv
// rtl/comp_1b_pkg.sv - shared types and helpers for the 1-bit comparator slice
package comp_pkg;

    // Cascade state handed from a more-significant slice to the next one down
    typedef struct packed {
        logic gt;
        logic eq;
    } casc_t;

    // The top slice has nothing above it: nothing decided yet, all equal so far
    localparam casc_t CASC_TOP = '{gt: 1'b0, eq: 1'b1};

    // One-hot {gt, eq, lt}; NONE is the cleared/reset pattern
    typedef enum logic [2:0] {
        CMP_NONE = 3'b000,
        CMP_GT   = 3'b100,
        CMP_EQ   = 3'b010,
        CMP_LT   = 3'b001
    } cmp_result_t;

    // Local greater-than for one bit; a set sign bit means negative, so the
    // sense flips in signed mode
    function automatic logic local_gt(input logic a, input logic b, input logic sign_mode);
        return sign_mode ? (~a & b) : (a & ~b);
    endfunction

    // Bits agree regardless of signedness
    function automatic logic local_eq(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

    // Fold the cascaded gt/eq pair into the one-hot result; gt wins over eq
    // so an illegal (1,1) cascade still yields exactly one hot bit
    function automatic cmp_result_t to_result(input logic gt_c, input logic eq_c);
        if (gt_c) begin
            return CMP_GT;
        end else if (eq_c) begin
            return CMP_EQ;
        end
        return CMP_LT;
    endfunction

endpackage

// File: rtl/comp_1b_if.sv
// rtl/comp_1b_if.sv - operand, cascade and result bundle of one comparator slice
interface comp_1b_if;
    logic in_valid;
    logic a;
    logic b;
    logic sign_mode;
    logic casc_gt_in;
    logic casc_eq_in;
    logic out_valid;
    logic gt;
    logic eq;
    logic lt;
    logic gt_comb;
    logic eq_comb;

    // Source of operands and consumer of results
    modport master (
        output in_valid, a, b, sign_mode, casc_gt_in, casc_eq_in,
        input  out_valid, gt, eq, lt, gt_comb, eq_comb
    );

    // The comparator slice itself
    modport slave (
        input  in_valid, a, b, sign_mode, casc_gt_in, casc_eq_in,
        output out_valid, gt, eq, lt, gt_comb, eq_comb
    );
endinterface

// File: rtl/comp_1b_core.sv
// rtl/comp_1b_core.sv - combinational local compare plus cascade merge
module comp_1b_core
    import comp_pkg::*;
(
    input  logic  a,
    input  logic  b,
    input  logic  sign_mode,
    input  casc_t casc,
    output logic  gt_comb,
    output logic  eq_comb
);

    logic gt_l;
    logic eq_l;

    // Local terms, then let upstream decisions dominate: a decided gt sticks,
    // and this bit only matters while everything above is still equal
    always_comb begin
        gt_l    = local_gt(a, b, sign_mode);
        eq_l    = local_eq(a, b);
        gt_comb = casc.gt | (casc.eq & gt_l);
        eq_comb = ~casc.gt & casc.eq & eq_l;
    end

endmodule

// File: rtl/comp_1b.sv
// rtl/comp_1b.sv - 1-bit cascadable magnitude comparator with optional output register
module comp_1b
    import comp_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    comp_1b_if.slave  bus
);

    casc_t       casc_in;
    logic        gt_c;
    logic        eq_c;
    cmp_result_t res_c;
    cmp_result_t res_q;
    logic        valid_q;
    logic [2:0]  res_bits;

    assign casc_in = '{gt: bus.casc_gt_in, eq: bus.casc_eq_in};

    comp_1b_core u_core (
        .a         (bus.a),
        .b         (bus.b),
        .sign_mode (bus.sign_mode),
        .casc      (casc_in),
        .gt_comb   (gt_c),
        .eq_comb   (eq_c)
    );

    // Ripple outputs bypass valid, clock and reset so chained slices settle freely
    assign bus.gt_comb = gt_c;
    assign bus.eq_comb = eq_c;

    assign res_c = to_result(gt_c, eq_c);

    generate
        if (REG_OUT) begin : g_reg
            // Result register loads only on valid beats and holds otherwise;
            // valid is simply delayed a cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q   <= CMP_NONE;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        res_q <= res_c;
                    end
                end
            end
        end else begin : g_comb
            // Pass-through; reset still clears the result and valid immediately
            always_comb begin
                res_q   = rst ? CMP_NONE : res_c;
                valid_q = bus.in_valid & ~rst;
            end
        end
    endgenerate

    assign res_bits      = res_q;
    assign bus.gt        = res_bits[2];
    assign bus.eq        = res_bits[1];
    assign bus.lt        = res_bits[0];
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_comp_1b.sv
// tb/tb_comp_1b.sv - scoreboard bench for registered and pass-through comparator slices
module tb_comp_1b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [2:0] exp_q[$];

    comp_1b_if bus0 ();
    comp_1b_if bus1 ();

    comp_1b #(.REG_OUT(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(bus0));
    comp_1b #(.REG_OUT(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: treat each bit as a number (signed bit = 0 or -1) and
    // compare, unless the cascade already decided
    function automatic logic [2:0] model(input logic a, input logic b, input logic sm,
                                         input logic cg, input logic ce);
        int va;
        int vb;
        if (cg) return 3'b100;
        if (!ce) return 3'b001;
        va = sm ? -int'(a) : int'(a);
        vb = sm ? -int'(b) : int'(b);
        if (va > vb) return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic a, input logic b, input logic sm,
                         input logic cg, input logic ce);
        logic [2:0] e;
        e = model(a, b, sm, cg, ce);
        bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.sign_mode = sm;
        bus0.casc_gt_in = cg; bus0.casc_eq_in = ce;
        bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.sign_mode = sm;
        bus1.casc_gt_in = cg; bus1.casc_eq_in = ce;
        #1;
        chk("reg_comb_gt_eq", {30'd0, bus0.gt_comb, bus0.eq_comb}, {30'd0, e[2], e[1]});
        chk("pass_result", {29'd0, bus1.gt, bus1.eq, bus1.lt},
            rst ? 32'd0 : {29'd0, e});
        chk("pass_valid", {31'd0, bus1.out_valid}, {31'd0, v & ~rst});
        if (v && !rst) exp_q.push_back(e);
    endtask

    // Monitor: every registered result must match the oldest expectation
    always @(negedge clk) begin
        if (bus0.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("reg_result", {29'd0, bus0.gt, bus0.eq, bus0.lt}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic a;
        logic b;
        logic sm;
        logic cg;
        logic ce;
    } vec_t;

    vec_t dir[$];

    initial begin
        bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.sign_mode = 0;
        bus0.casc_gt_in = 0; bus0.casc_eq_in = 1;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.sign_mode = 0;
        bus1.casc_gt_in = 0; bus1.casc_eq_in = 1;
        #2;
        chk("reset_reg_outputs", {28'd0, bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 32'd0);
        chk("reset_pass_outputs", {28'd0, bus1.out_valid, bus1.gt, bus1.eq, bus1.lt}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Directed: unsigned, signed, cascade overrides, back to back
        dir = '{'{0,0,0,0,1}, '{1,0,0,0,1}, '{0,1,0,0,1}, '{1,1,0,0,1},
                '{1,0,1,0,1}, '{0,1,1,0,1}, '{1,1,1,0,1},
                '{0,1,0,1,0}, '{0,1,0,0,0}, '{0,1,0,1,1}};
        foreach (dir[i]) begin
            drive(1, dir[i].a, dir[i].b, dir[i].sm, dir[i].cg, dir[i].ce);
            step();
        end

        // Hold: load gt, then idle while toggling operands
        drive(1, 1, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1);
            step();
            chk("hold_gt", {31'd0, bus0.gt}, 32'd1);
            chk("hold_valid_low", {31'd0, bus0.out_valid}, 32'd0);
        end

        // Asynchronous reset between edges while gt is held
        chk("pre_reset_gt", {31'd0, bus0.gt}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_reg", {28'd0, bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 32'd0);
        chk("async_reset_pass", {28'd0, bus1.out_valid, bus1.gt, bus1.eq, bus1.lt}, 32'd0);
        drive(1, 1, 0, 0, 0, 1);
        step();
        chk("reset_held_reg", {28'd0, bus0.out_valid, bus0.gt, bus0.eq, bus0.lt}, 32'd0);
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 1);
        step();

        // Random mix, including illegal and upstream-decided cascades
        for (int i = 0; i < 300; i++) begin
            logic cg;
            logic ce;
            case ($urandom_range(0, 5))
                3: begin cg = 1; ce = 0; end
                4: begin cg = 0; ce = 0; end
                5: begin cg = 1; ce = 1; end
                default: begin cg = 0; ce = 1; end
            endcase
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cg, ce);
            step();
        end

        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comp_1b.md
Name: comp_1b

Overview:
- Single-bit magnitude comparator slice with registered outputs.
- Compares one bit of operand a against one bit of operand b and reports greater-than, equal and less-than.
- Cascade inputs allow N slices to chain, most-significant slice first, into a wide comparator.
- A signed-mode input makes the top slice treat its bit as a two's-complement sign bit.

Parameters:
- REG_OUT, 1, 1 = gt/eq/lt/out_valid registered (1-cycle latency); 0 = outputs follow the combinational result and reset/valid still gate out_valid.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a/b/cascade inputs are valid this cycle
- a  input  1  operand A bit
- b  input  1  operand B bit
- sign_mode  input  1  1 = this bit is a two's-complement sign bit (MSB slice only)
- casc_gt_in  input  1  more-significant slices already decided A>B; tie 0 on the top slice
- casc_eq_in  input  1  more-significant slices all equal; tie 1 on the top slice
- out_valid  output  1  gt/eq/lt hold a valid result
- gt  output  1  A > B
- eq  output  1  A == B
- lt  output  1  A < B
- gt_comb  output  1  unregistered gt, for ripple cascading into the next slice
- eq_comb  output  1  unregistered eq, for ripple cascading into the next slice

Behaviour:
- Local terms, unsigned (sign_mode=0): gt_l = a & ~b; eq_l = ~(a ^ b).
- Local terms, signed (sign_mode=1): gt_l = ~a & b, since a positive A beats a negative B; eq_l = ~(a ^ b).
- Cascade: gt_comb = casc_gt_in | (casc_eq_in & gt_l); eq_comb = ~casc_gt_in & casc_eq_in & eq_l.
- lt = ~gt & ~eq, so exactly one of gt/eq/lt is 1 whenever out_valid=1.
- Illegal cascade casc_gt_in=1 with casc_eq_in=1: gt takes priority, giving gt=1, eq=0, lt=0.
- casc_gt_in=0 with casc_eq_in=0 means less-than was already decided upstream: gt=0, eq=0, lt=1.
- gt_comb/eq_comb are purely combinational and independent of in_valid, clk and rst.
- REG_OUT=1: on a rising clk edge with in_valid=1, the registers gt/eq/lt load the combinational result.
- REG_OUT=1: with in_valid=0, gt/eq/lt hold their previous value.
- REG_OUT=1: out_valid is in_valid delayed by one cycle.
- REG_OUT=0: gt/eq/lt equal the combinational result; out_valid = in_valid & ~rst.
- Reset (asserted at any time, including mid-stream): gt=0, eq=0, lt=0, out_valid=0 immediately, without waiting for a clock edge.
- After reset deasserts, the first valid result appears one edge after the first in_valid=1 cycle (REG_OUT=1).
- Back-to-back in_valid=1 gives one result per cycle with no bubbles.
- There is no backpressure.

Decomposition:
- Shared package comp_pkg holds:
  - typedef casc_t {gt, eq};
  - constant CASC_TOP = '{gt:0, eq:1};
  - constant cmp_result_t encoding GT/EQ/LT.
- One sub-module, comp_1b_core: purely combinational local + cascade logic (a, b, sign_mode, casc in → gt_comb, eq_comb).
- comp_1b wraps comp_1b_core with the output register stage, valid pipeline and the REG_OUT generate.

Test Plan:
- Top-slice cascade (0,1), sign_mode=0, REG_OUT=1, the four pairs each with in_valid=1:
  - a=0,b=0 → next cycle gt=0 eq=1 lt=0 out_valid=1
  - a=1,b=0 → gt=1 eq=0 lt=0
  - a=0,b=1 → gt=0 eq=0 lt=1
  - a=1,b=1 → gt=0 eq=1 lt=0
- sign_mode=1, top cascade:
  - a=1,b=0 → gt=0 lt=1
  - a=0,b=1 → gt=1 lt=0
  - a=b=1 → eq=1
- Cascade override with a=0,b=1:
  - casc (gt=1,eq=0) → gt=1
  - casc (0,0) → lt=1
  - casc (1,1) → gt=1 eq=0
- Hold and valid: load a=1,b=0, then drop in_valid for 3 cycles while toggling a/b → gt stays 1, out_valid=0 after one cycle, gt_comb tracks the inputs.
- Reset mid-operation: assert rst asynchronously between edges while gt=1 → gt=eq=lt=out_valid=0 immediately. Release rst, apply a=b=0 valid → eq=1 one edge later.
- REG_OUT=0 build: a=1,b=0 with in_valid=1 → gt=1 and out_valid=1 in the same cycle. Raise rst → out_valid=0.
